// File: rtl/spi_cfg_pkg.sv
// Shared command codes, register map, FSM states and error-bit layout
// for the SPI command/configuration controller.
package spi_cfg_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ERR_W  = 4;

  typedef logic [BYTE_W-1:0] byte_t;

  localparam byte_t CMD_WR = 8'hA5;
  localparam byte_t CMD_RD = 8'h5A;

  localparam byte_t ADDR_CTRL   = 8'd0;
  localparam byte_t ADDR_YUZHI  = 8'd1;
  localparam byte_t ADDR_CHSEL  = 8'd2;
  localparam byte_t ADDR_STATUS = 8'd3;

  localparam int unsigned ERR_CMD     = 0;
  localparam int unsigned ERR_ADDR    = 1;
  localparam int unsigned ERR_TIMEOUT = 2;
  localparam int unsigned ERR_ABORT   = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W_ADDR,
    ST_W_DATA,
    ST_R_ADDR,
    ST_R_DUMMY
  } state_e;

  function automatic logic addr_legal(input byte_t addr);
    return addr <= ADDR_STATUS;
  endfunction

endpackage

// File: rtl/spi_cmd_ctrl_if.sv
// Byte-level handshake between the SPI slave shifter and the command controller.
interface spi_cmd_ctrl_if;
  import spi_cfg_pkg::*;

  logic  rxd_flag;
  byte_t rxd_data;
  byte_t txd_data;
  logic  txd_load;

  // SPI slave shifter side
  modport master (output rxd_flag, rxd_data, input txd_data, txd_load);
  // Command controller side
  modport slave  (input rxd_flag, rxd_data, output txd_data, txd_load);

endinterface

// File: rtl/cs_sync_edge.sv
// Two-flop synchronizer for the asynchronous SPI chip select plus a
// deassert (rising-edge) detector in the sclk domain.
module cs_sync_edge (
  input  logic sclk,
  input  logic s_rst,
  input  logic spi_cs,
  output logic cs_rise_c
);

  logic cs_meta;
  logic cs_sync;
  logic cs_prev;

  always_ff @(posedge sclk) begin
    if (s_rst) begin
      cs_meta <= 1'b1;
      cs_sync <= 1'b1;
      cs_prev <= 1'b1;
    end else begin
      cs_meta <= spi_cs;
      cs_sync <= cs_meta;
      cs_prev <= cs_sync;
    end
  end

  assign cs_rise_c = cs_sync & ~cs_prev;

endmodule

// File: rtl/spi_cmd_ctrl.sv
// Decodes framed SPI write/read commands into a small configuration register
// set, returns readback bytes, and aborts malformed frames with sticky errors.
module spi_cmd_ctrl
  import spi_cfg_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC   = 50000,
  parameter byte_t       YUZHI_DEFAULT = 8'd60,
  parameter byte_t       CH_DEFAULT    = 8'd0
) (
  input  logic             sclk,
  input  logic             s_rst,
  input  logic             spi_cs,
  spi_cmd_ctrl_if.slave    bus,
  output logic             led,
  output byte_t            yuzhi,
  output byte_t            ch_select,
  output logic             cfg_update,
  output logic [ERR_W-1:0] err_status
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_e            state_q, state_n;
  byte_t             addr_q;
  logic [CNT_W-1:0]  to_cnt_q;
  logic              cs_rise_c;
  logic              timeout_c;
  logic              wr_en_c;
  logic              rd_en_c;
  logic [ERR_W-1:0]  err_set_c;
  logic [ERR_W-1:0]  w1c_mask_c;
  byte_t             rd_val_c;

  cs_sync_edge u_cs_sync_edge (
    .sclk      (sclk),
    .s_rst     (s_rst),
    .spi_cs    (spi_cs),
    .cs_rise_c (cs_rise_c)
  );

  // A byte arriving in the expiry cycle clears the counter, so it takes priority.
  assign timeout_c = (state_q != ST_IDLE) && !bus.rxd_flag &&
                     (to_cnt_q >= CNT_W'(TIMEOUT_CYC));

  assign w1c_mask_c = (wr_en_c && (addr_q == ADDR_STATUS)) ?
                      bus.rxd_data[ERR_W-1:0] : '0;

  always_ff @(posedge sclk) begin
    if (s_rst) state_q <= ST_IDLE;
    else       state_q <= state_n;
  end

  // Next state and per-cycle actions; chip-select abort outranks any byte.
  always_comb begin
    state_n   = state_q;
    wr_en_c   = 1'b0;
    rd_en_c   = 1'b0;
    err_set_c = '0;
    if ((state_q != ST_IDLE) && cs_rise_c) begin
      err_set_c[ERR_ABORT] = 1'b1;
      state_n              = ST_IDLE;
    end else if (bus.rxd_flag) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.rxd_data == CMD_WR)      state_n = ST_W_ADDR;
          else if (bus.rxd_data == CMD_RD) state_n = ST_R_ADDR;
          else                             err_set_c[ERR_CMD] = 1'b1;
        end
        ST_W_ADDR: state_n = ST_W_DATA;
        ST_W_DATA: begin
          state_n = ST_IDLE;
          if (addr_legal(addr_q)) wr_en_c = 1'b1;
          else                    err_set_c[ERR_ADDR] = 1'b1;
        end
        ST_R_ADDR: begin
          state_n = ST_R_DUMMY;
          rd_en_c = 1'b1;
          if (!addr_legal(bus.rxd_data)) err_set_c[ERR_ADDR] = 1'b1;
        end
        ST_R_DUMMY: state_n = ST_IDLE;
        default:    state_n = ST_IDLE;
      endcase
    end else if (timeout_c) begin
      err_set_c[ERR_TIMEOUT] = 1'b1;
      state_n                = ST_IDLE;
    end
  end

  // Readback mux, addressed directly by the incoming ADDR byte.
  always_comb begin
    rd_val_c = '0;
    case (bus.rxd_data)
      ADDR_CTRL:   rd_val_c = BYTE_W'(led);
      ADDR_YUZHI:  rd_val_c = yuzhi;
      ADDR_CHSEL:  rd_val_c = ch_select;
      ADDR_STATUS: rd_val_c = BYTE_W'(err_status);
      default:     rd_val_c = '0;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (s_rst) begin
      addr_q       <= '0;
      to_cnt_q     <= '0;
      led          <= 1'b1;
      yuzhi        <= YUZHI_DEFAULT;
      ch_select    <= CH_DEFAULT;
      cfg_update   <= 1'b0;
      err_status   <= '0;
      bus.txd_data <= '0;
      bus.txd_load <= 1'b0;
    end else begin
      cfg_update   <= 1'b0;
      bus.txd_load <= 1'b0;

      if ((state_q == ST_W_ADDR) && (state_n == ST_W_DATA)) addr_q <= bus.rxd_data;

      if (bus.rxd_flag || (state_q == ST_IDLE))   to_cnt_q <= '0;
      else if (to_cnt_q < CNT_W'(TIMEOUT_CYC))    to_cnt_q <= to_cnt_q + CNT_W'(1);

      if (rd_en_c) begin
        bus.txd_data <= rd_val_c;
        bus.txd_load <= 1'b1;
      end

      if (wr_en_c) begin
        case (addr_q)
          ADDR_CTRL:  begin led       <= bus.rxd_data[0]; cfg_update <= 1'b1; end
          ADDR_YUZHI: begin yuzhi     <= bus.rxd_data;    cfg_update <= 1'b1; end
          ADDR_CHSEL: begin ch_select <= bus.rxd_data;    cfg_update <= 1'b1; end
          default:    ;
        endcase
      end

      // New error sets override a same-cycle W1C clear.
      err_status <= (err_status & ~w1c_mask_c) | err_set_c;
    end
  end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Directed self-checking bench for spi_cmd_ctrl.
module tb_spi_cmd_ctrl;

  localparam int unsigned TO     = 50000;
  localparam logic [7:0]  Y_DEF  = 8'd60;
  localparam logic [7:0]  CH_DEF = 8'd0;

  logic       sclk = 1'b0;
  logic       s_rst;
  logic       spi_cs;
  logic       led;
  logic [7:0] yuzhi;
  logic [7:0] ch_select;
  logic       cfg_update;
  logic [3:0] err_status;

  int tests_run    = 0;
  int tests_failed = 0;

  spi_cmd_ctrl_if bus ();

  spi_cmd_ctrl #(
    .TIMEOUT_CYC   (TO),
    .YUZHI_DEFAULT (Y_DEF),
    .CH_DEFAULT    (CH_DEF)
  ) dut (
    .sclk       (sclk),
    .s_rst      (s_rst),
    .spi_cs     (spi_cs),
    .bus        (bus),
    .led        (led),
    .yuzhi      (yuzhi),
    .ch_select  (ch_select),
    .cfg_update (cfg_update),
    .err_status (err_status)
  );

  always #5 sclk = ~sclk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rxd_flag = 1'b1;
    bus.rxd_data = b;
    tick();
    bus.rxd_flag = 1'b0;
  endtask

  task automatic do_reset();
    s_rst        = 1'b1;
    spi_cs       = 1'b0;
    bus.rxd_flag = 1'b0;
    bus.rxd_data = 8'h00;
    repeat (3) tick();
    s_rst = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++; if (led !== 1'b1) begin tests_failed++; $display("FAIL rst_led: got %b exp 1", led); end
    tests_run++; if (yuzhi !== Y_DEF) begin tests_failed++; $display("FAIL rst_yuzhi: got %h exp %h", yuzhi, Y_DEF); end
    tests_run++; if (ch_select !== CH_DEF) begin tests_failed++; $display("FAIL rst_ch: got %h exp %h", ch_select, CH_DEF); end
    tests_run++; if (err_status !== 4'b0000) begin tests_failed++; $display("FAIL rst_err: got %b exp 0000", err_status); end
    tests_run++; if ({bus.txd_load, bus.txd_data, cfg_update} !== 10'd0) begin tests_failed++; $display("FAIL rst_tx: got load=%b data=%h cfg=%b exp all 0", bus.txd_load, bus.txd_data, cfg_update); end
  endtask

  task automatic test_write();
    do_reset();
    send_byte(8'hA5); send_byte(8'h01);
    tests_run++; if (yuzhi !== Y_DEF) begin tests_failed++; $display("FAIL wr_early: got %h exp %h", yuzhi, Y_DEF); end
    send_byte(8'h80);
    tests_run++; if (yuzhi !== 8'h80) begin tests_failed++; $display("FAIL wr_yuzhi: got %h exp 80", yuzhi); end
    tests_run++; if (cfg_update !== 1'b1) begin tests_failed++; $display("FAIL wr_cfg_pulse: got %b exp 1", cfg_update); end
    tick();
    tests_run++; if (cfg_update !== 1'b0) begin tests_failed++; $display("FAIL wr_cfg_single: got %b exp 0", cfg_update); end
    tests_run++; if (err_status !== 4'b0000) begin tests_failed++; $display("FAIL wr_err: got %b exp 0000", err_status); end
  endtask

  task automatic test_read();
    do_reset();
    send_byte(8'h5A);
    tests_run++; if (bus.txd_load !== 1'b0) begin tests_failed++; $display("FAIL rd_early_load: got %b exp 0", bus.txd_load); end
    send_byte(8'h02);
    tests_run++; if (bus.txd_load !== 1'b1) begin tests_failed++; $display("FAIL rd_load: got %b exp 1", bus.txd_load); end
    tests_run++; if (bus.txd_data !== CH_DEF) begin tests_failed++; $display("FAIL rd_chsel: got %h exp %h", bus.txd_data, CH_DEF); end
    tick();
    tests_run++; if (bus.txd_load !== 1'b0) begin tests_failed++; $display("FAIL rd_load_single: got %b exp 0", bus.txd_load); end
    send_byte(8'h00);
    send_byte(8'h5A); send_byte(8'h01);
    tests_run++; if (bus.txd_data !== Y_DEF || bus.txd_load !== 1'b1) begin tests_failed++; $display("FAIL rd_yuzhi: got %h/%b exp %h/1", bus.txd_data, bus.txd_load, Y_DEF); end
    send_byte(8'h00);
    send_byte(8'h5A); send_byte(8'h00);
    tests_run++; if (bus.txd_data !== 8'h01) begin tests_failed++; $display("FAIL rd_ctrl: got %h exp 01", bus.txd_data); end
    send_byte(8'h00);
  endtask

  task automatic test_cmd_err();
    do_reset();
    send_byte(8'h3C);
    tests_run++; if (err_status !== 4'b0001) begin tests_failed++; $display("FAIL cmd_err: got %b exp 0001", err_status); end
    send_byte(8'h5A); send_byte(8'h03);
    tests_run++; if (bus.txd_data !== 8'h01) begin tests_failed++; $display("FAIL rd_status: got %h exp 01", bus.txd_data); end
    send_byte(8'h00);
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h01);
    tests_run++; if (err_status !== 4'b0000) begin tests_failed++; $display("FAIL w1c_clear: got %b exp 0000", err_status); end
    tests_run++; if (cfg_update !== 1'b0) begin tests_failed++; $display("FAIL w1c_no_cfg: got %b exp 0", cfg_update); end
  endtask

  task automatic test_timeout();
    do_reset();
    send_byte(8'hA5); send_byte(8'h01);
    repeat (TO - 1) tick();
    tests_run++; if (err_status !== 4'b0000) begin tests_failed++; $display("FAIL to_early: got %b exp 0000", err_status); end
    repeat (2) tick();
    tests_run++; if (err_status !== 4'b0100) begin tests_failed++; $display("FAIL to_err: got %b exp 0100", err_status); end
    tests_run++; if (yuzhi !== Y_DEF) begin tests_failed++; $display("FAIL to_yuzhi: got %h exp %h", yuzhi, Y_DEF); end
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
    tests_run++; if (led !== 1'b0) begin tests_failed++; $display("FAIL to_next_led: got %b exp 0", led); end
    tests_run++; if (err_status !== 4'b0100) begin tests_failed++; $display("FAIL to_sticky: got %b exp 0100", err_status); end
  endtask

  task automatic test_abort();
    do_reset();
    send_byte(8'hA5); send_byte(8'h02);
    // Two synchronizer stages put the detected edge in the data byte's cycle.
    spi_cs = 1'b1;
    repeat (2) tick();
    send_byte(8'h55);
    tests_run++; if (ch_select !== CH_DEF) begin tests_failed++; $display("FAIL abort_ch: got %h exp %h", ch_select, CH_DEF); end
    tests_run++; if (err_status !== 4'b1000) begin tests_failed++; $display("FAIL abort_err: got %b exp 1000", err_status); end
    tests_run++; if (cfg_update !== 1'b0) begin tests_failed++; $display("FAIL abort_cfg: got %b exp 0", cfg_update); end
    spi_cs = 1'b0;
    repeat (3) tick();
    spi_cs = 1'b1;
    repeat (4) tick();
    tests_run++; if (err_status !== 4'b1000) begin tests_failed++; $display("FAIL idle_cs_ignored: got %b exp 1000", err_status); end
    spi_cs = 1'b0;
    repeat (3) tick();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h66);
    tests_run++; if (ch_select !== 8'h66) begin tests_failed++; $display("FAIL abort_recover: got %h exp 66", ch_select); end
  endtask

  task automatic test_illegal_addr();
    do_reset();
    send_byte(8'hA5); send_byte(8'h07); send_byte(8'h11);
    tests_run++; if (err_status !== 4'b0010) begin tests_failed++; $display("FAIL ill_err: got %b exp 0010", err_status); end
    tests_run++; if ({led, yuzhi, ch_select, cfg_update} !== {1'b1, Y_DEF, CH_DEF, 1'b0}) begin tests_failed++; $display("FAIL ill_regs: got led=%b y=%h ch=%h cfg=%b", led, yuzhi, ch_select, cfg_update); end
    send_byte(8'h5A); send_byte(8'h07);
    tests_run++; if (bus.txd_load !== 1'b1 || bus.txd_data !== 8'h00) begin tests_failed++; $display("FAIL ill_read: got %h/%b exp 00/1", bus.txd_data, bus.txd_load); end
    send_byte(8'h00);
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
    tests_run++; if (led !== 1'b0 || cfg_update !== 1'b1) begin tests_failed++; $display("FAIL b2b_led: got led=%b cfg=%b exp 0/1", led, cfg_update); end
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h07);
    tests_run++; if (ch_select !== 8'h07 || cfg_update !== 1'b1) begin tests_failed++; $display("FAIL b2b_ch: got %h cfg=%b exp 07/1", ch_select, cfg_update); end
    send_byte(8'h5A); send_byte(8'h00);
    tests_run++; if (bus.txd_data !== 8'h00 || bus.txd_load !== 1'b1) begin tests_failed++; $display("FAIL b2b_rd_ctrl: got %h/%b exp 00/1", bus.txd_data, bus.txd_load); end
    send_byte(8'h00);
    send_byte(8'h5A); send_byte(8'h02);
    tests_run++; if (bus.txd_data !== 8'h07) begin tests_failed++; $display("FAIL b2b_rd_ch: got %h exp 07", bus.txd_data); end
    send_byte(8'h00);
  endtask

  task automatic test_mid_reset();
    do_reset();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h11);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'hA5); send_byte(8'h01);
    do_reset();
    tests_run++; if (yuzhi !== Y_DEF || led !== 1'b1) begin tests_failed++; $display("FAIL mrst_regs: got y=%h led=%b exp %h/1", yuzhi, led, Y_DEF); end
    send_byte(8'h80);
    tests_run++; if (err_status !== 4'b0001 || yuzhi !== Y_DEF) begin tests_failed++; $display("FAIL mrst_idle: got err=%b y=%h exp 0001/%h", err_status, yuzhi, Y_DEF); end
  endtask

  initial begin
    s_rst        = 1'b1;
    spi_cs       = 1'b0;
    bus.rxd_flag = 1'b0;
    bus.rxd_data = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_cmd_err();
    test_timeout();
    test_abort();
    test_illegal_addr();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
